sync_filter_bank: RTL and testbench
===================================

# sync_filter_bank

Parametrised multi-channel input conditioner: each of `WIDTH` asynchronous inputs passes through a `STAGES`-deep synchronizer and then a glitch filter that needs `FILTER_CNT` consecutive agreeing samples before the output changes. Optional per-channel rise and fall pulses are generated from the filtered level. The block sits at the boundary between off-chip or foreign-domain control and status bits and the core logic on `clk`. It replaces the fixed two-flop synchronizer for any signal that needs deeper metastability protection, debouncing or edge events.

## Interface
- `WIDTH`, 4: number of independent channels.
- `STAGES`, 2: synchronizer flops per channel; legal range is 2 or more.
- `FILTER_CNT`, 4: consecutive differing synced samples required to commit a change; legal range is 1 or more.
- `RST_VAL`, `{WIDTH{1'b0}}`: reset value of the synchronizer stages and of `out`.
- `clk` input, 1: clock. Reset `rst` is synchronous and active-high.
- `rst` input, 1: synchronous active-high reset.
- `in` input, WIDTH: asynchronous raw inputs.
- `out` output, WIDTH: synchronized, filtered levels.
- `rise` output, WIDTH: one-cycle pulse when `out[i]` goes 0 to 1.
- `fall` output, WIDTH: one-cycle pulse when `out[i]` goes 1 to 0.
- `changed` output, 1: OR of all `rise` and `fall` bits.

## Operation
- Channels are fully independent. There is no cross-channel coherence, so multi-bit buses must not rely on this block.
- **Sync chain, per channel:** on each edge, `stage[0] <= in[i]` and `stage[k] <= stage[k-1]`. The synced value `s = stage[STAGES-1]`.
- **Filter, per channel:** counter `cnt` is `$clog2(FILTER_CNT)` bits wide, with a minimum of 1 bit.
  - If `s == out[i]`, then `cnt <= 0`.
  - If `s != out[i]` and `cnt == FILTER_CNT-1`, then `out[i] <= s` and `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
- With `FILTER_CNT=1`, `out` follows `s` after one extra register.
- A synced excursion shorter than `FILTER_CNT` cycles is discarded, and `cnt` returns to 0 the cycle `s` matches `out` again.
- `cnt` never wraps, because it is cleared on commit.
- **Edge pulses:** `rise[i]` and `fall[i]` are registered and set on the same edge that commits `out[i]`. Each is high for exactly one cycle, the first cycle `out` shows the new value.
  - `rise` and `fall` of the same channel are never both high.
  - `changed` is combinational from the registered `rise`/`fall`.
- **Reset:** all stages, `cnt` and `out` take `RST_VAL`; `rise`, `fall` and `changed` are 0. This holds from the cycle after the `rst` edge, including mid-filter, where a partial count is lost.
- After reset, if `in` is steady and differs from `RST_VAL`, `out` reaches `in` after the normal latency and the corresponding `rise`/`fall` pulse fires.

## Timing
- Latency: an `in` change that is stable before edge E1 appears on `out` at edge `E(STAGES+FILTER_CNT)`. With defaults, that is the 6th rising edge.
- The real-world latency adds up to 1 cycle of sampling uncertainty for asynchronous inputs.
- Minimum accepted pulse width at `in`: `FILTER_CNT` cycles, plus 1 for sampling uncertainty.
- Minimum spacing between successive commits on one channel: `FILTER_CNT` cycles.
- Reset is synchronous; outputs are at reset values one edge after `rst` is sampled high.

## Configuration
- Macro: `SYNC_FILTER_EDGE_EN`.
- **Defined:** `rise`, `fall` and `changed` behave as described under Operation.
- **Undefined:** the edge registers are not built. `rise`, `fall` and `changed` are tied to 0, and the ports remain present so instantiations do not change.

## Structure
- **Shared package `sync_pkg`:**
  - default constants `SYNC_STAGES_DEF = 2` and `SYNC_FILTER_DEF = 4`;
  - a counter-width helper constant or function, floored at 1 bit.
- **Sub-module `sync_filter_chan`:**
  - one bit containing the chain, filter and edge registers;
  - parameters `STAGES`, `FILTER_CNT` and a 1-bit `RST_VAL`;
  - the top generates `WIDTH` instances and ORs the edge outputs into `changed`.
- Elaboration-time checks reject `STAGES < 2` and `FILTER_CNT < 1`.

## Test plan
- **Defaults, steady step:** reset, then drive `in = 4'b0001` before edge E1. Required: `out[0]` becomes 1 at E6, `rise = 4'b0001` for one cycle, `changed = 1` for one cycle, and the other channels stay 0.
- **Glitch rejection:** pulse `in[1]` high for 3 cycles. Required: `out[1]` stays 0 and there is no `rise`/`fall`. A 4-cycle pulse (aligned) must produce `out[1]` high for 4 cycles with one `rise` and one `fall`.
- **Mid-filter reset:** start an `in[2]` 0-to-1 step and assert `rst` at E4 for one cycle. Required: `out = RST_VAL` from E5, and `out[2]` rises only `STAGES+FILTER_CNT` edges after `rst` is released, with a fresh count.
- **Parameter sweep:**

  | `STAGES` | `FILTER_CNT` | `WIDTH` | Required `out` latency |
  |---|---|---|---|
  | 3 | 1 | 8 | 4 edges |
  | 2 | 7 | 8 | 9 edges |

  Each configuration is tested with simultaneous opposite transitions on all 8 channels.
- **`RST_VAL = 4'b1111` with `in = 0`:** required `fall = 4'b1111` for one cycle, at edge `STAGES+FILTER_CNT` after reset release.
- **Macro undefined:** rerun the step test. Required: `out` timing is identical and `rise`, `fall` and `changed` stay 0 throughout.

Source files
------------

// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared defaults and counter-width helper for input synchronizers
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_FILTER_DEF = 4;

  // A filter of 1 or 2 samples still needs a 1-bit counter.
  function automatic int cnt_width(input int filter_cnt);
    return (filter_cnt <= 2) ? 1 : $clog2(filter_cnt);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// rtl/sync_filter_chan.sv - one-bit synchronizer chain, glitch filter and edge registers
// Edge registers are built only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = SYNC_STAGES_DEF,
  parameter int   FILTER_CNT = SYNC_FILTER_DEF,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int            CW      = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_filter_chan: STAGES must be 2 or more");
    end
    if (FILTER_CNT < 1) begin : g_bad_filter
      $error("sync_filter_chan: FILTER_CNT must be 1 or more");
    end
  endgenerate

  logic [STAGES-1:0] stage_q, stage_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              s;
  logic              commit;

  assign s = stage_q[STAGES-1];

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], in};
    cnt_d   = cnt_q;
    out_d   = out_q;
    commit  = 1'b0;
    // Any sample agreeing with the committed level discards a partial count.
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d  = s;
      cnt_d  = '0;
      commit = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {STAGES{RST_VAL}};
      cnt_q   <= '0;
      out_q   <= RST_VAL;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

`ifdef SYNC_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = commit & s;
    fall_d = commit & ~s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - WIDTH independent synchronize-and-debounce channels
// Optional rise/fall/changed events controlled by SYNC_FILTER_EDGE_EN.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = SYNC_STAGES_DEF,
  parameter int               FILTER_CNT = SYNC_FILTER_DEF,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Channels share nothing; a multi-bit bus gets no coherence guarantee here.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES    (STAGES),
      .FILTER_CNT(FILTER_CNT),
      .RST_VAL   (RST_VAL[i])
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .in  (in[i]),
      .out (out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_sync_filter_bank.sv
// tb/tb_sync_filter_bank.sv - scoreboard bench for sync_filter_bank
module tb_sync_filter_bank;

`ifdef SYNC_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  o;
    logic [7:0]  r;
    logic [7:0]  f;
    logic        ch;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst, rst_d;
  logic [3:0] in_a, in_d;
  logic [7:0] in_b, in_c;
  logic [3:0] out_a, rise_a, fall_a, out_d, rise_d, fall_d;
  logic [7:0] out_b, rise_b, fall_b, out_c, rise_c, fall_c;
  logic       chg_a, chg_b, chg_c, chg_d;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  evt_t q0[$], q1[$], q2[$], q3[$];
  logic [7:0] prev_o [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_filter_bank dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .changed(chg_a)
  );
  sync_filter_bank #(.WIDTH(8), .STAGES(3), .FILTER_CNT(1), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .changed(chg_b)
  );
  sync_filter_bank #(.WIDTH(8), .STAGES(2), .FILTER_CNT(7), .RST_VAL(8'h00)) dut_c (
    .clk(clk), .rst(rst), .in(in_c), .out(out_c),
    .rise(rise_c), .fall(fall_c), .changed(chg_c)
  );
  sync_filter_bank #(.RST_VAL(4'hF)) dut_d (
    .clk(clk), .rst(rst_d), .in(in_d), .out(out_d),
    .rise(rise_d), .fall(fall_d), .changed(chg_d)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int id, input int c, input logic [7:0] o,
                      input logic [7:0] r, input logic [7:0] f);
    evt_t e;
    e.cyc = c;
    e.o   = o;
    e.r   = EDGE ? r : 8'h00;
    e.f   = EDGE ? f : 8'h00;
    e.ch  = EDGE & ((|r) | (|f));
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // An event is any cycle where out moves or an edge/changed output is high.
  task automatic mon(input int id, input logic [7:0] o, input logic [7:0] r,
                     input logic [7:0] f, input logic ch);
    evt_t got, exp;
    bit   have;
    got.cyc = cyc;
    got.o   = o;
    got.r   = r;
    got.f   = f;
    got.ch  = ch;
    if (mon_en && (o !== prev_o[id] || r !== 8'h00 || f !== 8'h00 || ch !== 1'b0)) begin
      have = 1'b0;
      exp  = '0;
      case (id)
        0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
        2: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
        default: if (q3.size() > 0) begin exp = q3.pop_front(); have = 1'b1; end
      endcase
      n_checks++;
      if (!have || got !== exp) begin
        n_err++;
        $display("FAIL evt%0d got cyc=%0d out=%h rise=%h fall=%h chg=%b exp%s cyc=%0d out=%h rise=%h fall=%h chg=%b",
                 id, got.cyc, got.o, got.r, got.f, got.ch, have ? "" : "(none)",
                 exp.cyc, exp.o, exp.r, exp.f, exp.ch);
      end
    end
    prev_o[id] = o;
  endtask

  always @(negedge clk) mon(0, {4'h0, out_a}, {4'h0, rise_a}, {4'h0, fall_a}, chg_a);
  always @(negedge clk) mon(1, out_b, rise_b, fall_b, chg_b);
  always @(negedge clk) mon(2, out_c, rise_c, fall_c, chg_c);
  always @(negedge clk) mon(3, {4'h0, out_d}, {4'h0, rise_d}, {4'h0, fall_d}, chg_d);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1; rst_d = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    tick(3);

    check("rst_out_a", {28'h0, out_a}, 32'h0);
    check("rst_edges_a", {23'h0, rise_a, fall_a, chg_a}, 32'h0);
    check("rst_out_d", {28'h0, out_d}, 32'hF);
    check("rst_edges_d", {23'h0, rise_d, fall_d, chg_d}, 32'h0);
    check("rst_out_bc", {16'h0, out_b, out_c}, 32'h0);

    // Release reset and step channel 0 before the first live edge.
    rst = 1'b0; rst_d = 1'b0; mon_en = 1'b1;
    t = cyc;
    in_a = 4'b0001;
    push(0, t + 6, 8'h01, 8'h01, 8'h00);
    push(3, t + 6, 8'h00, 8'h00, 8'h0F);
    tick(12);

    // Three-cycle glitch must vanish; four cycles must pass through.
    in_a = 4'b0011;
    tick(3);
    in_a = 4'b0001;
    tick(12);
    t = cyc;
    in_a = 4'b0011;
    push(0, t + 6, 8'h03, 8'h02, 8'h00);
    tick(4);
    in_a = 4'b0001;
    push(0, t + 10, 8'h01, 8'h00, 8'h02);
    tick(12);

    // Reset lands mid-count on channel 2 and wipes channel 0's level.
    t = cyc;
    in_a = 4'b0101;
    tick(4);
    rst = 1'b1;
    push(0, t + 5, 8'h00, 8'h00, 8'h00);
    tick(1);
    rst = 1'b0;
    check("midrst_out_a", {28'h0, out_a}, 32'h0);
    push(0, t + 11, 8'h05, 8'h05, 8'h00);
    tick(14);

    // Opposite transitions on all eight channels for both sweep configurations.
    t = cyc;
    in_b = 8'h55; in_c = 8'h55;
    push(1, t + 4, 8'h55, 8'h55, 8'h00);
    push(2, t + 9, 8'h55, 8'h55, 8'h00);
    tick(12);
    t = cyc;
    in_b = 8'hAA; in_c = 8'hAA;
    push(1, t + 4, 8'hAA, 8'hAA, 8'h55);
    push(2, t + 9, 8'hAA, 8'hAA, 8'h55);
    tick(14);

    check("q0_left", q0.size(), 32'h0);
    check("q1_left", q1.size(), 32'h0);
    check("q2_left", q2.size(), 32'h0);
    check("q3_left", q3.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
